zacore_mem_arbiter: RTL

- Shares the single memory port between the fetch stage (instruction reads) and the memory stage (loads and stores).
- Sits between zacore_fetch / the load-store unit and the external memory interface.
- Data accesses take priority by default. A streak counter prevents fetch starvation.
- Every granted transaction is latched and run to completion. Withdrawn requests have their ack suppressed.

---
 rtl/zacore_mem_arbiter_pkg.sv | 38 +++
 rtl/zacore_mem_arbiter_streak.sv | 38 +++
 rtl/zacore_mem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/zacore_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zacore_mem_arbiter_pkg
// Description : Shared types and helpers for the zacore memory-port arbiter.
//               - arb_state_t   : arbiter FSM state encoding
//               - ARB_STREAK_W  : width of the data-grant streak counter
//               - streak_next() : saturating increment with clear priority
// Revision    : 1.0 - initial release
// ============================================================================
package zacore_mem_arbiter_pkg;

    // Width of the consecutive-data-grant counter. MAX_DATA_STREAK must fit.
    localparam int ARB_STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY_FETCH = 2'd1,
        BUSY_DATA  = 2'd2
    } arb_state_t;

    // Clear wins over increment; increment saturates at all ones.
    function automatic logic [ARB_STREAK_W-1:0] streak_next(
        input logic [ARB_STREAK_W-1:0] cur,
        input logic                    inc,
        input logic                    clr
    );
        logic [ARB_STREAK_W-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != '1)) begin
            nxt = cur + ARB_STREAK_W'(1);
        end
        return nxt;
    endfunction

endpackage : zacore_mem_arbiter_pkg
`default_nettype wire

// File: rtl/zacore_mem_arbiter_streak.sv
`default_nettype none
// ============================================================================
// Module      : zacore_mem_arbiter_streak
// Description : Counts consecutive data grants completed while fetch was
//               waiting, and flags when fetch must be given the next grant.
// Ports       : i_clk, i_rst  - clock, synchronous active-high reset
//               inc           - data completion with fetch waiting
//               clr           - fetch completion, or data completion with
//                               no fetch waiting
//               at_limit      - streak has reached MAX_DATA_STREAK
// Revision    : 1.0 - initial release
// ============================================================================
module zacore_mem_arbiter_streak
    import zacore_mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4      // 1..15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [ARB_STREAK_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else begin
            count <= streak_next(count, inc, clr);
        end
    end

    assign at_limit = (count >= ARB_STREAK_W'(MAX_DATA_STREAK));

endmodule : zacore_mem_arbiter_streak
`default_nettype wire

// File: rtl/zacore_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : zacore_mem_arbiter
// Description : Shares the single external memory port between instruction
//               fetch and the load/store unit. Data wins ties unless fetch
//               has been passed over MAX_DATA_STREAK times in a row. A grant
//               is latched and held until i_mem_ack; one idle cycle always
//               separates transactions.
// Ports       : i_clk / i_rst                  clock, sync active-high reset
//               i_fetch_* / o_fetch_*          instruction read port
//               i_data_*  / o_data_*           load/store port
//               o_mem_*   / i_mem_*            external memory port
// Revision    : 1.0 - initial release
// ============================================================================
module zacore_mem_arbiter
    import zacore_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,   // multiple of 8
    parameter int MAX_DATA_STREAK = 4     // 1..15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // fetch port
    input  logic                  i_fetch_req,
    input  logic [ADDR_W-1:0]     i_fetch_addr,
    output logic                  o_fetch_ack,
    output logic [DATA_W-1:0]     o_fetch_rdata,
    // data port
    input  logic                  i_data_req,
    input  logic                  i_data_we,
    input  logic [ADDR_W-1:0]     i_data_addr,
    input  logic [DATA_W-1:0]     i_data_wdata,
    input  logic [DATA_W/8-1:0]   i_data_be,
    output logic                  o_data_ack,
    output logic [DATA_W-1:0]     o_data_rdata,
    // memory port
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_be,
    input  logic                  i_mem_ack,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    // Latched request presented on the memory port for the whole transaction.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    arb_state_t state;
    mem_req_t   mem_q;
    logic       squash;       // fetch withdrew during its own transaction
    logic       streak_hit;   // fetch has waited long enough, it wins a tie

    logic busy;
    logic fetch_done;
    logic data_done;
    logic grant_data;
    logic grant_fetch;

    assign busy       = (state != IDLE);
    assign fetch_done = (state == BUSY_FETCH) & i_mem_ack;
    assign data_done  = (state == BUSY_DATA)  & i_mem_ack;

    assign grant_data  = i_data_req & ~(i_fetch_req & streak_hit);
    assign grant_fetch = i_fetch_req & ~grant_data;

    // ------------------------------------------------------------------
    // Arbiter FSM and request latch
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            mem_q  <= '0;
            squash <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    squash <= 1'b0;
                    if (grant_data) begin
                        state       <= BUSY_DATA;
                        mem_q.we    <= i_data_we;
                        mem_q.addr  <= i_data_addr;
                        mem_q.wdata <= i_data_wdata;
                        mem_q.be    <= i_data_be;
                    end else if (grant_fetch) begin
                        state       <= BUSY_FETCH;
                        mem_q.we    <= 1'b0;
                        mem_q.addr  <= i_fetch_addr;
                        mem_q.wdata <= '0;
                        mem_q.be    <= '1;
                    end
                end
                BUSY_FETCH: begin
                    if (i_mem_ack) begin
                        state  <= IDLE;
                        squash <= 1'b0;
                    end else if (!i_fetch_req) begin
                        // Sticky: a later re-assert is a new request and
                        // must not see this transaction's data.
                        squash <= 1'b1;
                    end
                end
                BUSY_DATA: begin
                    if (i_mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
    zacore_mem_arbiter_streak #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_streak (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .inc      (data_done & i_fetch_req),
        .clr      (fetch_done | (data_done & ~i_fetch_req)),
        .at_limit (streak_hit)
    );

    // ------------------------------------------------------------------
    // Outputs. The request drops combinationally on the ack so memory never
    // sees a second request for the completed transaction.
    // ------------------------------------------------------------------
    assign o_mem_req   = busy & ~i_mem_ack;
    assign o_mem_we    = mem_q.we;
    assign o_mem_addr  = mem_q.addr;
    assign o_mem_wdata = mem_q.wdata;
    assign o_mem_be    = mem_q.be;

    // A fetch that is low in the completion cycle has also withdrawn.
    assign o_fetch_ack   = fetch_done & ~squash & i_fetch_req & ~i_rst;
    assign o_data_ack    = data_done & ~i_rst;
    assign o_fetch_rdata = i_mem_rdata;
    assign o_data_rdata  = i_mem_rdata;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_no_ack_when_idle : assert property (
        @(posedge i_clk) disable iff (i_rst) (state == IDLE) |-> !i_mem_ack);

    a_data_held_until_ack : assert property (
        @(posedge i_clk) disable iff (i_rst) (state == BUSY_DATA) |-> i_data_req);

endmodule : zacore_mem_arbiter
`default_nettype wire
